// File: rtl/mips_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_fetch_pkg
//  Brief    : Shared types and constants for the MIPS instruction fetch stage
//  Revision : 1.0 - initial release
// ============================================================================
package mips_fetch_pkg;

    // Default fetch address after reset
    localparam logic [31:0] c_RESET_PC   = 32'h0000_0000;

    // Byte stride between consecutive instruction words
    localparam logic [31:0] c_WORD_BYTES = 32'd4;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

    // One buffered instruction together with the address it was fetched from
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_fifo
//  Brief    : Synchronous first-word-fall-through FIFO of fetch entries with
//             flush; head is a combinational read of the oldest entry
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import mips_fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic [AW:0]  count_o,
    output logic         empty_o,
    output logic         full_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;

    logic w_do_push;
    logic w_do_pop;

    // Flush wins over everything; popping an empty FIFO is ignored
    assign w_do_push = push_i && !flush_i;
    assign w_do_pop  = pop_i && !flush_i && !empty_o;

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of 2)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents need no reset because occupancy gates visibility
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));

endmodule
`default_nettype wire

// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_queue
//  Brief    : MIPS fetch stage: owns the fetch PC, issues credit-limited word
//             reads to instruction memory, buffers in-order responses and
//             hands {instr, pc, pc+4} to decode; redirects flush the queue
//             and discard stale in-flight responses
//  Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_queue
    import mips_fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = c_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_4
);

    localparam int AW = $clog2(DEPTH);

    fetch_state_e state_q;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  resp_pc_q,  resp_pc_d;
    logic [AW:0]  outstanding_q, outstanding_d;
    logic [AW:0]  drop_cnt_q,    drop_cnt_d;

    logic [31:0]  w_target;
    logic         w_req_fire;
    logic         w_keep;
    logic         w_pop;
    logic [AW+1:0] w_inflight;

    fetch_entry_t w_push_data;
    fetch_entry_t w_head;
    logic [AW:0]  w_fifo_count;
    logic         w_fifo_empty;
    logic         w_fifo_full;

    assign w_target = {redirect_pc[31:2], 2'b00};

    // Buffered plus outstanding words never exceed DEPTH, so a kept response always has a slot
    assign w_inflight     = {1'b0, w_fifo_count} + {1'b0, outstanding_q};
    assign imem_req_valid = (state_q != ST_IDLE) && !redirect_valid &&
                            (w_inflight < (AW+2)'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    // Response disposition and drop accounting. outstanding_q counts every word in
    // flight, stale or not, and drop_cnt_q counts the stale subset; on a redirect
    // everything still in flight after this cycle's response becomes stale.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        w_keep     = 1'b0;
        if (redirect_valid) begin
            drop_cnt_d = outstanding_q - (AW+1)'(imem_rsp_valid);
        end else if (imem_rsp_valid) begin
            if (drop_cnt_q != '0) begin
                drop_cnt_d = drop_cnt_q - (AW+1)'(1);
            end else begin
                w_keep = 1'b1;
            end
        end
    end

    // Next fetch/response PCs and in-flight count
    always_comb begin
        outstanding_d = outstanding_q + (AW+1)'(w_req_fire) - (AW+1)'(imem_rsp_valid);
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = w_target;
            resp_pc_d  = w_target;
        end else begin
            if (w_req_fire) begin
                fetch_pc_d = fetch_pc_q + c_WORD_BYTES;
            end
            if (w_keep) begin
                resp_pc_d = resp_pc_q + c_WORD_BYTES;
            end
        end
    end

    // PC and counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    // Fetch sequencer: one idle cycle after reset, FLUSH while stale words remain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:  state_q <= ST_RUN;
                ST_RUN:   if (redirect_valid && (drop_cnt_d != '0)) state_q <= ST_FLUSH;
                ST_FLUSH: if (drop_cnt_d == '0) state_q <= ST_RUN;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    // A redirect clears the queue and the head handshake of that cycle is not consumed
    assign w_pop             = out_valid && out_ready && !redirect_valid;
    assign w_push_data.instr = imem_rsp_data;
    assign w_push_data.pc    = resp_pc_q;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (w_keep),
        .push_data_i (w_push_data),
        .pop_i       (w_pop),
        .flush_i     (redirect_valid),
        .head_o      (w_head),
        .count_o     (w_fifo_count),
        .empty_o     (w_fifo_empty),
        .full_o      (w_fifo_full)
    );

    // Head fields read as zero while empty so out_pc_4 shows 4 out of reset
    assign out_valid = !w_fifo_empty;
    assign out_instr = w_fifo_empty ? 32'h0 : w_head.instr;
    assign out_pc    = w_fifo_empty ? 32'h0 : w_head.pc;
    assign out_pc_4  = out_pc + c_WORD_BYTES;

    // Credit accounting must make a kept response into a full, non-draining queue impossible
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(w_keep && w_fifo_full && !w_pop));

endmodule
`default_nettype wire
